// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle shift/rotate engine applying one single-bit step per clock, with start/busy/done handshake.
//   clk   : system clock, all state updates on posedge
//   rst   : synchronous active-high reset
//   start : request, accepted only when not busy (IDLE or DONE)
//   op    : 3-bit shift opcode, latched on accepted start
//   din   : operand, latched on accepted start
//   amt   : step count, latched on accepted start
//   busy  : high while stepping
//   done  : one-cycle pulse when dout/carry/zero hold the final result
//   dout  : working/result register
//   carry : last bit shifted or rotated out
//   zero  : dout == 0, registered alongside dout
module shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] din,
    input  logic [AMT_W-1:0] amt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic             carry,
    output logic             zero
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_nx;
    logic [2:0] op_q;
    logic [AMT_W-1:0] cnt;
    logic accept, skip;
    logic [WIDTH-1:0] step_d;
    logic step_c;
    assign accept = start && state != SHIFT;
    // pass opcodes (001, 101) and zero amounts complete without stepping
    assign skip = amt == '0 || op[1:0] == 2'b01;
    assign busy = state == SHIFT;
    assign done = state == DONE;
    always_comb begin
        state_nx = accept ? (skip ? DONE : SHIFT) :
                   state == SHIFT ? (cnt == AMT_W'(1) ? DONE : SHIFT) : IDLE;
    end
    always_comb begin
        step_d = dout;
        step_c = 1'b0;
        case (op_q)
            3'b000: begin step_d = {dout[WIDTH-2:0], dout[WIDTH-1]}; step_c = dout[WIDTH-1]; end
            3'b100: begin step_d = {dout[0], dout[WIDTH-1:1]}; step_c = dout[0]; end
            3'b010, 3'b011: begin step_d = {dout[WIDTH-2:0], 1'b0}; step_c = dout[WIDTH-1]; end
            3'b110: begin step_d = {dout[WIDTH-1], dout[WIDTH-1:1]}; step_c = dout[0]; end
            3'b111: begin step_d = {1'b0, dout[WIDTH-1:1]}; step_c = dout[0]; end
            default: ;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            op_q  <= '0;
            cnt   <= '0;
            dout  <= '0;
            carry <= 1'b0;
            zero  <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op_q  <= op;
                cnt   <= amt;
                dout  <= din;
                carry <= 1'b0;
                zero  <= din == '0;
            end else if (state == SHIFT) begin
                cnt   <= cnt - AMT_W'(1);
                dout  <= step_d;
                carry <= step_c;
                zero  <= step_d == '0;
            end
        end
    end
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: randomized self-checking bench for shift_sequencer against a closed-form shift model.
module tb_shift_sequencer;
    logic clk = 0, rst = 1, start = 0;
    logic [2:0] op = 0;
    logic [7:0] din = 0;
    logic [2:0] amt = 0;
    logic busy, done, carry, zero;
    logic [7:0] dout;
    int n_checks = 0, n_fail = 0;

    shift_sequencer #(.WIDTH(8), .AMT_W(3)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .din(din), .amt(amt),
        .busy(busy), .done(done), .dout(dout), .carry(carry), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // result after k steps in closed form: {carry, value}
    function automatic logic [8:0] model(input logic [2:0] o, input logic [7:0] d, input int k);
        int dd, s, r, c;
        dd = int'(d);
        r = dd;
        c = 0;
        if (k > 0 && o[1:0] != 2'b01) begin
            case (o)
                3'b000: begin r = ((dd << k) | (dd >> (8 - k))) & 255; c = r & 1; end
                3'b100: begin r = ((dd >> k) | (dd << (8 - k))) & 255; c = (r >> 7) & 1; end
                3'b110: begin s = d[7] ? dd - 256 : dd; r = (s >>> k) & 255; c = (dd >> (k - 1)) & 1; end
                3'b111: begin r = dd >> k; c = (dd >> (k - 1)) & 1; end
                default: begin r = (dd << k) & 255; c = (dd >> (8 - k)) & 1; end
            endcase
        end
        return {c[0], r[7:0]};
    endfunction

    // called at a negedge; poke = step index at which a stray start is pulsed, abort = step index at which rst hits
    task automatic run(input logic [2:0] o, input logic [7:0] d, input logic [2:0] a, input int poke, input int abort);
        int n;
        logic [8:0] e;
        n = (a == 0 || o[1:0] == 2'b01) ? 0 : int'(a);
        start = 1; op = o; din = d; amt = a;
        @(negedge clk);
        start = 0; op = 3'($urandom); din = 8'($urandom); amt = 3'($urandom);
        for (int k = 0; k <= n; k++) begin
            if (k == abort) begin
                rst = 1;
                @(negedge clk);
                rst = 0;
                check("abort_dout", dout, 0);
                check("abort_carry", carry, 0);
                check("abort_zero", zero, 0);
                for (int j = 0; j < 3; j++) begin
                    check("abort_done", done, 0);
                    check("abort_busy", busy, 0);
                    @(negedge clk);
                end
                return;
            end
            e = model(o, d, k);
            if (k < n) begin
                check("step_busy", busy, 1);
                check("step_done", done, 0);
                check("step_dout", dout, e[7:0]);
                if (k == poke) begin
                    start = 1; op = 3'b001; din = 8'($urandom); amt = 3'($urandom);
                end
                @(negedge clk);
                start = 0;
            end else begin
                check("fin_done", done, 1);
                check("fin_busy", busy, 0);
                check("fin_dout", dout, e[7:0]);
                check("fin_carry", carry, e[8]);
                check("fin_zero", zero, e[7:0] == 0);
            end
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dout", dout, 0);
        check("rst_carry", carry, 0);
        check("rst_zero", zero, 0);
        rst = 0;
        @(negedge clk);
        run(3'b000, 8'h81, 3'd3, -1, -1);
        @(negedge clk);
        run(3'b110, 8'h80, 3'd7, -1, -1);
        run(3'b111, 8'h01, 3'd1, -1, -1);
        run(3'b011, 8'hFF, 3'd7, -1, -1);
        run(3'b001, 8'h5A, 3'd5, -1, -1);
        run(3'b100, 8'h01, 3'd0, -1, -1);
        run(3'b100, 8'h96, 3'd7, 2, -1);
        run(3'b010, 8'hC3, 3'd6, -1, 3);
        run(3'b111, 8'h80, 3'd7, -1, -1);
        run(3'b000, 8'h00, 3'd4, -1, -1);
        for (int i = 0; i < 60; i++) begin
            run(3'($urandom), 8'($urandom), 3'($urandom),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : -1,
                ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : -1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
